bbs_generator: RTL and testbench

BBS_GENERATOR -- requirements
Module: bbs_generator

---
 rtl/bbs_pkg.sv | 23 ++
 rtl/mod_square_seq.sv | 89 ++++++++
 rtl/bbs_generator.sv | 132 +++++++++++++
 tb/tb_bbs_generator.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bbs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bbs_pkg
// Brief    : Shared constants for the Blum-Blum-Shub generator: default
//            parameters and the 2-bit FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package bbs_pkg;

    // Default generator parameters
    localparam int BBS_SIZE_DEF = 16;
    localparam int BBS_MOD_DEF  = 40633;
    localparam int BBS_SEED_DEF = 884;

    // FSM state encoding
    typedef logic [1:0] bbs_fsm_t;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SQUARE = 2'd1;
    localparam logic [1:0] ST_UPDATE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mod_square_seq.sv
`default_nettype none
// ============================================================================
// Module   : mod_square_seq
// Brief    : Sequential modular squarer, out = x*x mod MOD. MSB-first
//            double-and-add, one step per clock with conditional subtraction
//            on a SIZE+1-bit intermediate. The first step runs on the go
//            edge, so done is high SIZE cycles after go. x must be < MOD.
// Revision : 1.0 - initial release
// ============================================================================
module mod_square_seq
    import bbs_pkg::*;
#(
    parameter int SIZE = BBS_SIZE_DEF,
    parameter int MOD  = BBS_MOD_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            go,
    input  logic [SIZE-1:0] x,
    output logic            done,
    output logic [SIZE-1:0] out
);

    localparam int            IW    = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [SIZE:0] MOD_W = (SIZE+1)'(MOD);

    logic [SIZE-1:0] x_q;
    logic [SIZE-1:0] acc_q;
    logic [IW-1:0]   idx_q;
    logic            run_q;
    logic            done_q;

    logic [SIZE-1:0] acc_in;
    logic [SIZE-1:0] addend;
    logic            mul_bit;
    logic [SIZE:0]   dbl;
    logic [SIZE:0]   dbl_sub;
    logic [SIZE-1:0] dbl_red;
    logic [SIZE:0]   sum;
    logic [SIZE:0]   sum_sub;
    logic [SIZE-1:0] step;

    // One double-and-add step; a borrow in the top bit means "no subtract"
    always_comb begin
        acc_in  = go ? '0 : acc_q;
        addend  = go ? x : x_q;
        mul_bit = go ? x[SIZE-1] : x_q[idx_q];
        dbl     = {acc_in, 1'b0};
        dbl_sub = dbl - MOD_W;
        dbl_red = dbl_sub[SIZE] ? dbl[SIZE-1:0] : dbl_sub[SIZE-1:0];
        sum     = {1'b0, dbl_red} + {1'b0, addend};
        sum_sub = sum - MOD_W;
        step    = dbl_red;
        if (mul_bit) begin
            step = sum_sub[SIZE] ? sum[SIZE-1:0] : sum_sub[SIZE-1:0];
        end
    end

    // Operand capture, accumulator and bit index sequencing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q    <= '0;
            acc_q  <= '0;
            idx_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (go) begin
            x_q    <= x;
            acc_q  <= step;
            idx_q  <= IW'(SIZE - 2);
            run_q  <= (SIZE > 1);
            done_q <= (SIZE == 1);
        end else if (run_q) begin
            acc_q <= step;
            idx_q <= idx_q - IW'(1);
            if (idx_q == '0) begin
                run_q  <= 1'b0;
                done_q <= 1'b1;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign done = done_q;
    assign out  = acc_q;

endmodule
`default_nettype wire

// File: rtl/bbs_generator.sv
`default_nettype none
// ============================================================================
// Module   : bbs_generator
// Brief    : Blum-Blum-Shub pseudo-random word generator. Each output bit
//            costs SIZE squaring cycles plus one UPDATE cycle; the finished
//            OUT_W-bit word is held with valid until ready.
//            Build option BBS_PARITY_EN: extracted bit is the XOR of all state
//            bits instead of the state LSB. Timing is identical either way.
// Revision : 1.0 - initial release
// ============================================================================
module bbs_generator
    import bbs_pkg::*;
#(
    parameter int SIZE  = BBS_SIZE_DEF,
    parameter int MOD   = BBS_MOD_DEF,
    parameter int SEED  = BBS_SEED_DEF,
    parameter int OUT_W = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             seed_load,
    input  logic [SIZE-1:0]  seed_in,
    input  logic             ready,
    output logic             busy,
    output logic             valid,
    output logic [OUT_W-1:0] result
);

    localparam int               CW       = $clog2(OUT_W + 1);
    localparam logic [SIZE-1:0]  MOD_C    = SIZE'(MOD);
    localparam logic [SIZE-1:0]  SEED_C   = SIZE'(SEED);
    localparam logic [CW-1:0]    OUT_W_C  = CW'(OUT_W);

    bbs_fsm_t         fsm_q,    fsm_d;
    logic [SIZE-1:0]  state_q,  state_d;
    logic [OUT_W-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q,    cnt_d;

    logic             sq_go;
    logic             sq_done;
    logic [SIZE-1:0]  sq_out;
    logic             ext_bit;
    logic             seed_ok;

    // The squarer is fed from state_d so a new bit can start on the UPDATE edge
    mod_square_seq #(
        .SIZE (SIZE),
        .MOD  (MOD)
    ) u_sq (
        .clk   (clk),
        .reset (reset),
        .go    (sq_go),
        .x     (state_d),
        .done  (sq_done),
        .out   (sq_out)
    );

`ifdef BBS_PARITY_EN
    assign ext_bit = ^sq_out;
`else
    assign ext_bit = sq_out[0];
`endif

    // Seeds 0, 1 and >= MOD would lock the sequence, so they fall back to SEED
    assign seed_ok = (seed_in >= SIZE'(2)) && (seed_in < MOD_C);

    // Next-state logic for FSM, BBS state, result shifter and bit counter
    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        sq_go    = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                if (seed_load) begin
                    state_d = seed_ok ? seed_in : SEED_C;
                end else if (start) begin
                    fsm_d    = ST_SQUARE;
                    result_d = '0;
                    cnt_d    = '0;
                    sq_go    = 1'b1;
                end
            end
            ST_SQUARE: begin
                if (sq_done) begin
                    fsm_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                state_d     = sq_out;
                result_d    = result_q << 1;
                result_d[0] = ext_bit;
                cnt_d       = cnt_q + CW'(1);
                if (cnt_d == OUT_W_C) begin
                    fsm_d = ST_DONE;
                end else begin
                    fsm_d = ST_SQUARE;
                    sq_go = 1'b1;
                end
            end
            ST_DONE: begin
                if (ready) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q    <= ST_IDLE;
            state_q  <= SEED_C;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy   = (fsm_q == ST_SQUARE) || (fsm_q == ST_UPDATE);
    assign valid  = (fsm_q == ST_DONE);
    assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_bbs_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_bbs_generator
// Brief    : Self-checking bench for bbs_generator (OUT_W = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bbs_generator;
    import bbs_pkg::*;

    localparam int SIZE  = 16;
    localparam int MOD   = 40633;
    localparam int SEED  = 884;
    localparam int OUT_W = 8;
    localparam int BLEN  = SIZE + 1;
`ifdef BBS_PARITY_EN
    localparam logic [1:0] FIRST2 = 2'b10;
`else
    localparam logic [1:0] FIRST2 = 2'b11;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             seed_load;
    logic [SIZE-1:0]  seed_in;
    logic             ready;
    logic             busy;
    logic             valid;
    logic [OUT_W-1:0] result;

    int               n_vec = 0;
    int               n_bad = 0;
    logic [OUT_W-1:0] sb[$];
    logic [SIZE-1:0]  m_state;

    typedef struct {
        logic [SIZE-1:0] seed;
        logic [SIZE-1:0] exp_state;
    } seed_vec_t;
    seed_vec_t tbl[8];

    bbs_generator #(
        .SIZE  (SIZE),
        .MOD   (MOD),
        .SEED  (SEED),
        .OUT_W (OUT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .ready     (ready),
        .busy      (busy),
        .valid     (valid),
        .result    (result)
    );

    always #5 clk = ~clk;

    function automatic logic [SIZE-1:0] sqm(input logic [SIZE-1:0] s);
        logic [63:0] p;
        p = {48'd0, s} * {48'd0, s};
        p = p % 64'(MOD);
        return p[SIZE-1:0];
    endfunction

    function automatic logic xbit(input logic [SIZE-1:0] s);
`ifdef BBS_PARITY_EN
        return ^s;
`else
        return s[0];
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Push the model word, start, optionally poke ignored inputs mid-word,
    // wait for valid and compare against the scoreboard head.
    task automatic run_word(input bit poke, output logic [OUT_W-1:0] got,
                            output logic [SIZE-1:0] st1, output logic [SIZE-1:0] st2);
        logic [SIZE-1:0]  s;
        logic [SIZE-1:0]  exp1;
        logic [SIZE-1:0]  exp2;
        logic [OUT_W-1:0] w;
        logic [OUT_W-1:0] exp_w;
        int               e;
        bit               seen;
        s    = m_state;
        w    = '0;
        exp1 = sqm(m_state);
        exp2 = sqm(exp1);
        for (int i = 0; i < OUT_W; i++) begin
            s = sqm(s);
            w = (w << 1) | OUT_W'(xbit(s));
        end
        sb.push_back(w);
        m_state = s;
        st1 = '0;
        st2 = '0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        e    = 0;
        seen = 1'b0;
        while (!seen && e < 4000) begin
            if (poke && e == 40) begin
                seed_in   = 16'd1000;
                seed_load = 1'b1;
                start     = 1'b1;
                ready     = 1'b1;
            end
            @(posedge clk);
            #1;
            e++;
            seed_load = 1'b0;
            start     = 1'b0;
            ready     = 1'b0;
            if (e == BLEN) begin
                st1 = dut.state_q;
                chk("state_bit0", {48'd0, dut.state_q}, {48'd0, exp1});
                chk("lsb_bit0", {63'd0, result[0]}, {63'd0, xbit(exp1)});
            end
            if (e == 2 * BLEN) begin
                st2 = dut.state_q;
                chk("state_bit1", {48'd0, dut.state_q}, {48'd0, exp2});
            end
            if (valid) seen = 1'b1;
        end
        chk("valid_edge", 64'(e), 64'(OUT_W * BLEN));
        got   = result;
        exp_w = sb.pop_front();
        chk("word", {56'd0, result}, {56'd0, exp_w});
    endtask

    task automatic ack();
        @(negedge clk);
        ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
        chk("ack_valid", {63'd0, valid}, 64'd0);
        chk("ack_fsm", {62'd0, dut.fsm_q}, {62'd0, ST_IDLE});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [OUT_W-1:0] w1;
        logic [OUT_W-1:0] w2;
        logic [OUT_W-1:0] w3;
        logic [SIZE-1:0]  s1;
        logic [SIZE-1:0]  s2;

        tbl[0] = '{16'd0,     16'd884};
        tbl[1] = '{16'd40633, 16'd884};
        tbl[2] = '{16'd1,     16'd884};
        tbl[3] = '{16'd1000,  16'd1000};
        tbl[4] = '{16'd2,     16'd2};
        tbl[5] = '{16'd40632, 16'd40632};
        tbl[6] = '{16'd65535, 16'd884};
        tbl[7] = '{16'd884,   16'd884};

        reset = 1'b1; start = 1'b0; seed_load = 1'b0; seed_in = '0; ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   {63'd0, busy}, 64'd0);
        chk("rst_valid",  {63'd0, valid}, 64'd0);
        chk("rst_result", {56'd0, result}, 64'd0);
        chk("rst_state",  {48'd0, dut.state_q}, 64'(SEED));
        chk("rst_fsm",    {62'd0, dut.fsm_q}, {62'd0, ST_IDLE});
        @(negedge clk) reset = 1'b0;
        m_state = 16'(SEED);

        // First word from reset seed
        run_word(1'b0, w1, s1, s2);
        chk("s1_state1", {48'd0, s1}, 64'd9429);
        chk("s1_state2", {48'd0, s2}, 64'd1037);
        chk("s1_first2", {62'd0, w1[OUT_W-1 -: 2]}, {62'd0, FIRST2});

        // Hold in DONE with ready low
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            chk("hold_result", {56'd0, result}, {56'd0, w1});
            chk("hold_busy",   {63'd0, busy}, 64'd0);
            chk("hold_valid",  {63'd0, valid}, 64'd1);
        end
        ack();

        // Second word continues the sequence; stray inputs mid-word ignored
        run_word(1'b1, w2, s1, s2);
        ack();

        // Seed load table
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seed_in   = tbl[i].seed;
            seed_load = 1'b1;
            @(posedge clk);
            #1 seed_load = 1'b0;
            chk("seed_load", {48'd0, dut.state_q}, {48'd0, tbl[i].exp_state});
            chk("seed_busy", {63'd0, busy}, 64'd0);
        end

        // start and seed_load together: seed wins, start dropped
        @(negedge clk);
        seed_in = 16'd1234; seed_load = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 seed_load = 1'b0; start = 1'b0;
        chk("both_state", {48'd0, dut.state_q}, 64'd1234);
        for (int i = 0; i < 3; i++) begin
            chk("both_busy", {63'd0, busy}, 64'd0);
            @(posedge clk);
            #1;
        end
        chk("both_fsm", {62'd0, dut.fsm_q}, {62'd0, ST_IDLE});

        // Asynchronous reset mid-SQUARE of bit 5
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5 * BLEN + 3) @(posedge clk);
        #1;
        chk("pre_rst_busy", {63'd0, busy}, 64'd1);
        @(negedge clk) reset = 1'b1;
        #1;
        chk("mid_rst_busy",   {63'd0, busy}, 64'd0);
        chk("mid_rst_valid",  {63'd0, valid}, 64'd0);
        chk("mid_rst_result", {56'd0, result}, 64'd0);
        chk("mid_rst_state",  {48'd0, dut.state_q}, 64'(SEED));
        @(negedge clk) reset = 1'b0;
        m_state = 16'(SEED);
        run_word(1'b0, w3, s1, s2);
        chk("rerun_word", {56'd0, w3}, {56'd0, w1});
        ack();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
